// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB-Lite bus types and the arbiter's state and owner encodings.
// Imported by the arbiter top and its priority sub-module.
package ahb_master_arbiter_pkg;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } transfer_size;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1
    } transfer_burst;

    // Bit 0 distinguishes data access (1) from opcode fetch (0).
    typedef enum logic [3:0] {
        PROT_OPCODE = 4'b0000,
        PROT_DATA   = 4'b0001
    } transfer_protection;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } transfer_kind;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } transfer_response;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/ahb_arb_priority.sv
// Grant decision between fetch and data, with the fetch anti-starvation counter.
// The decision is combinational; only the counter is registered.
module ahb_arb_priority
    import ahb_master_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   arb_en_i,
    input  logic   f_req_i,
    input  logic   d_req_i,
    output logic   grant_o,
    output owner_e owner_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved_s;

    // Grant selection and next starve count.
    always_comb begin
        starved_s    = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        grant_o      = arb_en_i & (f_req_i | d_req_i);
        owner_o      = OWNER_DATA;
        starve_cnt_d = starve_cnt_q;
        if (f_req_i && (!d_req_i || starved_s)) begin
            owner_o = OWNER_FETCH;
        end else begin
            owner_o = OWNER_DATA;
        end
        if (grant_o) begin
            if (owner_o == OWNER_FETCH) begin
                starve_cnt_d = '0;
            end else if (f_req_i && !starved_s) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB-Lite master port between instruction fetch and load/store,
// one non-pipelined transfer at a time, with registered bus and completion outputs.
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               f_req_i,
    input  logic [ADDR_W-1:0]  f_addr_i,
    output logic               f_done_o,
    output logic [DATA_W-1:0]  f_rdata_o,
    output logic               f_err_o,
    input  logic               d_req_i,
    input  logic               d_write_i,
    input  logic [ADDR_W-1:0]  d_addr_i,
    input  transfer_size       d_size_i,
    input  logic [DATA_W-1:0]  d_wdata_i,
    output logic               d_done_o,
    output logic [DATA_W-1:0]  d_rdata_o,
    output logic               d_err_o,
    output logic [ADDR_W-1:0]  haddr_o,
    output logic               hwrite_o,
    output transfer_size       hsize_o,
    output transfer_burst      hburst_o,
    output transfer_protection hprot_o,
    output transfer_kind       htrans_o,
    output logic [DATA_W-1:0]  hwdata_o,
    input  logic [DATA_W-1:0]  hrdata_i,
    input  logic               hready_i,
    input  transfer_response   hresp_i
);

    arb_state_e         state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [ADDR_W-1:0]  haddr_q, haddr_d;
    logic               hwrite_q, hwrite_d;
    transfer_size       hsize_q, hsize_d;
    transfer_protection hprot_q, hprot_d;
    transfer_kind       htrans_q, htrans_d;
    logic [DATA_W-1:0]  hwdata_q, hwdata_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               f_done_q, f_done_d;
    logic [DATA_W-1:0]  f_rdata_q, f_rdata_d;
    logic               f_err_q, f_err_d;
    logic               d_done_q, d_done_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               d_err_q, d_err_d;

    logic               grant_s;
    owner_e             grant_owner_s;

    ahb_arb_priority #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk_i    (clock_i),
        .rst_ni   (reset_ni),
        .arb_en_i (state_q == ARB_IDLE),
        .f_req_i  (f_req_i),
        .d_req_i  (d_req_i),
        .grant_o  (grant_s),
        .owner_o  (grant_owner_s)
    );

    // Transfer sequencing: IDLE -> ADDR -> DATA -> IDLE.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        hprot_d   = hprot_q;
        htrans_d  = htrans_q;
        hwdata_d  = hwdata_q;
        wdata_d   = wdata_q;
        f_done_d  = 1'b0;
        f_rdata_d = f_rdata_q;
        f_err_d   = f_err_q;
        d_done_d  = 1'b0;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_s) begin
                    state_d  = ARB_ADDR;
                    owner_d  = grant_owner_s;
                    htrans_d = TRANS_NONSEQ;
                    if (grant_owner_s == OWNER_FETCH) begin
                        haddr_d  = f_addr_i;
                        hwrite_d = 1'b0;
                        hsize_d  = SIZE_WORD;
                        hprot_d  = PROT_OPCODE;
                        wdata_d  = '0;
                    end else begin
                        haddr_d  = d_addr_i;
                        hwrite_d = d_write_i;
                        hsize_d  = d_size_i;
                        hprot_d  = PROT_DATA;
                        wdata_d  = d_wdata_i;
                    end
                end else begin
                    htrans_d = TRANS_IDLE;
                end
            end
            ARB_ADDR: begin
                if (hready_i) begin
                    state_d  = ARB_DATA;
                    htrans_d = TRANS_IDLE;
                    hwdata_d = wdata_q;
                end else begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                // An ERROR cycle with hready low is the first half of a two-cycle response.
                if (hready_i) begin
                    state_d = ARB_IDLE;
                    if (owner_q == OWNER_FETCH) begin
                        f_rdata_d = hrdata_i;
                        f_err_d   = (hresp_i == RESP_ERROR);
                        f_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = hrdata_i;
                        d_err_d   = (hresp_i == RESP_ERROR);
                        d_done_d  = 1'b1;
                    end
                end else begin
                    state_d = ARB_DATA;
                end
            end
            default: begin
                state_d  = ARB_IDLE;
                htrans_d = TRANS_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_DATA;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= SIZE_BYTE;
            hprot_q   <= PROT_OPCODE;
            htrans_q  <= TRANS_IDLE;
            hwdata_q  <= '0;
            wdata_q   <= '0;
            f_done_q  <= 1'b0;
            f_rdata_q <= '0;
            f_err_q   <= 1'b0;
            d_done_q  <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            hprot_q   <= hprot_d;
            htrans_q  <= htrans_d;
            hwdata_q  <= hwdata_d;
            wdata_q   <= wdata_d;
            f_done_q  <= f_done_d;
            f_rdata_q <= f_rdata_d;
            f_err_q   <= f_err_d;
            d_done_q  <= d_done_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
        end
    end

    assign f_done_o  = f_done_q;
    assign f_rdata_o = f_rdata_q;
    assign f_err_o   = f_err_q;
    assign d_done_o  = d_done_q;
    assign d_rdata_o = d_rdata_q;
    assign d_err_o   = d_err_q;
    assign haddr_o   = haddr_q;
    assign hwrite_o  = hwrite_q;
    assign hsize_o   = hsize_q;
    assign hburst_o  = BURST_SINGLE;
    assign hprot_o   = hprot_q;
    assign htrans_o  = htrans_q;
    assign hwdata_o  = hwdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed self-checking bench for ahb_master_arbiter: latency, wait states,
// starvation ordering, ERROR responses, asynchronous reset and input latching.
module tb_ahb_master_arbiter;
    import ahb_master_arbiter_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               f_req;
    logic [31:0]        f_addr;
    logic               f_done;
    logic [31:0]        f_rdata;
    logic               f_err;
    logic               d_req;
    logic               d_write;
    logic [31:0]        d_addr;
    transfer_size       d_size;
    logic [31:0]        d_wdata;
    logic               d_done;
    logic [31:0]        d_rdata;
    logic               d_err;
    logic [31:0]        haddr;
    logic               hwrite;
    transfer_size       hsize;
    transfer_burst      hburst;
    transfer_protection hprot;
    transfer_kind       htrans;
    logic [31:0]        hwdata;
    logic [31:0]        hrdata;
    logic               hready;
    transfer_response   hresp;

    int tests_run    = 0;
    int tests_failed = 0;

    ahb_master_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_W(32),
        .DATA_W(32)
    ) u_dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .f_req_i  (f_req),
        .f_addr_i (f_addr),
        .f_done_o (f_done),
        .f_rdata_o(f_rdata),
        .f_err_o  (f_err),
        .d_req_i  (d_req),
        .d_write_i(d_write),
        .d_addr_i (d_addr),
        .d_size_i (d_size),
        .d_wdata_i(d_wdata),
        .d_done_o (d_done),
        .d_rdata_o(d_rdata),
        .d_err_o  (d_err),
        .haddr_o  (haddr),
        .hwrite_o (hwrite),
        .hsize_o  (hsize),
        .hburst_o (hburst),
        .hprot_o  (hprot),
        .htrans_o (htrans),
        .hwdata_o (hwdata),
        .hrdata_i (hrdata),
        .hready_i (hready),
        .hresp_i  (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] order_got;
        logic [9:0] order_exp;
        int         n_done;
        int         done_seen;

        rst_n = 1'b0; f_req = 1'b0; f_addr = 32'h0;
        d_req = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_size = SIZE_WORD; d_wdata = 32'h0;
        hrdata = 32'h0; hready = 1'b1; hresp = RESP_OKAY;

        // Reset state.
        #12;
        check_eq("rst_htrans", 64'(htrans), 64'(TRANS_IDLE));
        check_eq("rst_haddr",  64'(haddr),  64'h0);
        check_eq("rst_hwdata", 64'(hwdata), 64'h0);
        check_eq("rst_dones",  64'({f_done, d_done, f_err, d_err}), 64'h0);
        check_eq("rst_rdata",  64'({f_rdata, d_rdata}), 64'h0);
        check_eq("rst_hburst", 64'(hburst), 64'(BURST_SINGLE));
        rst_n = 1'b1;
        tick();

        // Fetch only, zero wait.
        f_req = 1'b1; f_addr = 32'h100; hrdata = 32'hDEADBEEF;
        tick();
        check_eq("f1_htrans", 64'(htrans), 64'(TRANS_NONSEQ));
        check_eq("f1_haddr",  64'(haddr),  64'h100);
        check_eq("f1_hprot",  64'(hprot),  64'(PROT_OPCODE));
        check_eq("f1_hsize",  64'(hsize),  64'(SIZE_WORD));
        check_eq("f1_ddone1", 64'(d_done), 64'h0);
        tick();
        check_eq("f1_c2done", 64'(f_done), 64'h0);
        check_eq("f1_ddone2", 64'(d_done), 64'h0);
        tick();
        f_req = 1'b0;
        check_eq("f1_done",  64'(f_done),  64'h1);
        check_eq("f1_rdata", 64'(f_rdata), 64'hDEADBEEF);
        check_eq("f1_err",   64'(f_err),   64'h0);
        check_eq("f1_ddone3", 64'(d_done), 64'h0);
        tick();
        check_eq("f1_pulse", 64'(f_done), 64'h0);

        // Store, HALF, two data-phase wait states.
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h804; d_size = SIZE_HALF; d_wdata = 32'h1234;
        hrdata = 32'h0;
        tick();
        check_eq("st_htrans", 64'(htrans), 64'(TRANS_NONSEQ));
        check_eq("st_hwrite", 64'(hwrite), 64'h1);
        check_eq("st_hsize",  64'(hsize),  64'(SIZE_HALF));
        check_eq("st_haddr",  64'(haddr),  64'h804);
        check_eq("st_hprot",  64'(hprot),  64'(PROT_DATA));
        tick();
        hready = 1'b0;
        check_eq("st_hwdata2", 64'(hwdata), 64'h1234);
        check_eq("st_idle2",   64'(htrans), 64'(TRANS_IDLE));
        tick();
        check_eq("st_hwdata3", 64'(hwdata), 64'h1234);
        check_eq("st_done3",   64'(d_done), 64'h0);
        tick();
        hready = 1'b1;
        check_eq("st_hwdata4", 64'(hwdata), 64'h1234);
        check_eq("st_done4",   64'(d_done), 64'h0);
        tick();
        d_req = 1'b0;
        check_eq("st_done5",  64'(d_done),  64'h1);
        check_eq("st_fdone",  64'(f_done),  64'h0);
        check_eq("st_frdata", 64'(f_rdata), 64'hDEADBEEF);
        tick();

        // Both requesting continuously: D,D,D,D,F,D,D,D,D,F.
        f_req = 1'b1; f_addr = 32'h200;
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h300; d_size = SIZE_WORD;
        order_exp = 10'b1000010000;
        order_got = 10'h0;
        n_done = 0;
        for (int cyc = 0; cyc < 60 && n_done < 10; cyc++) begin
            tick();
            if (f_done && d_done) begin
                check_eq("sv_both_done", 64'h1, 64'h0);
            end
            if (f_done || d_done) begin
                order_got[n_done] = f_done;
                n_done = n_done + 1;
                if (n_done == 10) begin
                    f_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        f_req = 1'b0;
        d_req = 1'b0;
        check_eq("sv_count", 64'(n_done), 64'd10);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("sv_order%0d", i), 64'(order_got[i]), 64'(order_exp[i]));
        end
        tick();

        // Load with a two-cycle ERROR response, then an OKAY transfer.
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h40; d_size = SIZE_WORD; hrdata = 32'h11112222;
        tick();
        tick();
        hready = 1'b0; hresp = RESP_ERROR;
        tick();
        check_eq("er_wait_done", 64'(d_done), 64'h0);
        hready = 1'b1;
        tick();
        check_eq("er_done",  64'(d_done), 64'h1);
        check_eq("er_err",   64'(d_err),  64'h1);
        hresp = RESP_OKAY; hrdata = 32'h33334444;
        tick();
        check_eq("er_hold", 64'(d_err), 64'h1);
        tick();
        tick();
        d_req = 1'b0;
        check_eq("ok_done",  64'(d_done),  64'h1);
        check_eq("ok_err",   64'(d_err),   64'h0);
        check_eq("ok_rdata", 64'(d_rdata), 64'h33334444);
        tick();

        // Reset asserted during ADDR with hready low.
        f_req = 1'b1; f_addr = 32'h500; hready = 1'b0; hrdata = 32'h55556666;
        tick();
        check_eq("rs_addr", 64'(htrans), 64'(TRANS_NONSEQ));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rs_async_htrans", 64'(htrans), 64'(TRANS_IDLE));
        check_eq("rs_async_haddr",  64'(haddr),  64'h0);
        hready = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            done_seen = done_seen | int'(f_done) | int'(d_done);
        end
        check_eq("rs_no_done", 64'(done_seen), 64'h0);
        #3;
        rst_n = 1'b1;
        tick();
        check_eq("rs_fresh_htrans", 64'(htrans), 64'(TRANS_NONSEQ));
        check_eq("rs_fresh_haddr",  64'(haddr),  64'h500);
        tick();
        tick();
        f_req = 1'b0;
        check_eq("rs_fresh_done",  64'(f_done),  64'h1);
        check_eq("rs_fresh_rdata", 64'(f_rdata), 64'h55556666);
        tick();

        // d_addr changed during DATA must not disturb the latched transfer.
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h600; d_size = SIZE_WORD; hrdata = 32'h00600600;
        tick();
        tick();
        hready = 1'b0; d_addr = 32'hABC; d_size = SIZE_BYTE;
        tick();
        check_eq("lt_haddr", 64'(haddr), 64'h600);
        check_eq("lt_hsize", 64'(hsize), 64'(SIZE_WORD));
        hready = 1'b1;
        tick();
        d_req = 1'b0;
        check_eq("lt_done",   64'(d_done),  64'h1);
        check_eq("lt_rdata",  64'(d_rdata), 64'h00600600);
        check_eq("lt_haddr2", 64'(haddr),   64'h600);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
